// File: rtl/axis_pkg.sv
// Shared constants and helpers for the byte-stream serializer.
package axis_pkg;

  localparam int unsigned BYTE_WIDTH   = 8;
  localparam int unsigned ORDER_LITTLE = 0;
  localparam int unsigned ORDER_BIG    = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

  // Requested byte count, with zero or oversize requests meaning a full word.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned max_bytes);
    return ((len == 0) || (len > max_bytes)) ? max_bytes : len;
  endfunction

endpackage

// File: rtl/axis_word_serializer.sv
// Wide-word to 8-bit AXI4-Stream serializer with optional frame-end tlast.
module axis_word_serializer
  import axis_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned BIG_ENDIAN = 0,
  localparam int unsigned LEN_WIDTH = $clog2(WORD_WIDTH / 8 + 1)
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic [WORD_WIDTH-1:0] s_word,
  input  logic [LEN_WIDTH-1:0]  s_len,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int unsigned         NUM_BYTES = WORD_WIDTH / BYTE_WIDTH;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_TWO  = LEN_WIDTH'(2);

  ser_state_e            state_q, state_d;
  logic                  run_q;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic                  last_q, last_d;
  logic [7:0]            tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic                  accept_c;
  logic                  beat_c;
  logic [LEN_WIDTH-1:0]  load_len_c;
  logic [WORD_WIDTH-1:0] aligned_c;

  // Byte at the output end of the shift register.
  function automatic logic [7:0] head_byte(input logic [WORD_WIDTH-1:0] w);
    if (BIG_ENDIAN == ORDER_BIG) return w[WORD_WIDTH-1 -: BYTE_WIDTH];
    return w[BYTE_WIDTH-1:0];
  endfunction

  // Move the next byte to the output end.
  function automatic logic [WORD_WIDTH-1:0] advance(input logic [WORD_WIDTH-1:0] w);
    if (BIG_ENDIAN == ORDER_BIG) return w << BYTE_WIDTH;
    return w >> BYTE_WIDTH;
  endfunction

  // Ready may pass a new word in on the same edge the final byte leaves (tready -> s_ready path).
  assign s_ready  = run_q && ((state_q == ST_IDLE) || (m_axis_tready && (remaining_q == LEN_ONE)));
  assign accept_c = s_valid && s_ready;
  assign beat_c   = (state_q == ST_SEND) && m_axis_tready;

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = (state_q == ST_SEND);
  assign m_axis_tlast  = tlast_q;

  // Next-state and datapath selection: load a word, advance a byte, or hold.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    shift_d     = shift_q;
    last_d      = last_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    load_len_c  = LEN_WIDTH'(eff_len(32'(s_len), NUM_BYTES));
    // Big-endian partial words: push the L low bytes up against the MSB end.
    if (BIG_ENDIAN == ORDER_BIG)
      aligned_c = s_word << (BYTE_WIDTH * (NUM_BYTES - 32'(load_len_c)));
    else
      aligned_c = s_word;

    if (accept_c) begin
      state_d     = ST_SEND;
      remaining_d = load_len_c;
      tdata_d     = head_byte(aligned_c);
      shift_d     = advance(aligned_c);
      last_d      = s_last;
      tlast_d     = s_last && (load_len_c == LEN_ONE);
    end else if (beat_c) begin
      if (remaining_q == LEN_ONE) begin
        state_d     = ST_IDLE;
        remaining_d = '0;
        tlast_d     = 1'b0;
      end else begin
        remaining_d = remaining_q - LEN_ONE;
        tdata_d     = head_byte(shift_q);
        shift_d     = advance(shift_q);
        tlast_d     = last_q && (remaining_q == LEN_TWO);
      end
    end
  end

  // State and datapath registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      remaining_q <= '0;
      shift_q     <= '0;
      last_q      <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      remaining_q <= remaining_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
    end
  end

endmodule

// File: tb/tb_axis_word_serializer.sv
// Bench for axis_word_serializer: little- and big-endian instances share stimulus.
module tb_axis_word_serializer;

  localparam int unsigned WW = 32;
  localparam int unsigned NB = WW / 8;
  localparam int unsigned LW = $clog2(WW / 8 + 1);

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic [WW-1:0] s_word;
  logic [LW-1:0] s_len;
  logic          s_last;
  logic          s_valid;
  logic          m_axis_tready;
  logic          le_ready, be_ready;
  logic [7:0]    le_data, be_data;
  logic          le_valid, be_valid;
  logic          le_last, be_last;

  int            n_cmp = 0;
  int            n_err = 0;
  logic          running;
  logic          rand_rdy;
  logic          accepted;
  logic          prev_stall;
  logic [8:0]    prev_le, prev_be;
  logic [8:0]    q_le[$];
  logic [8:0]    q_be[$];

  always #5 clk = ~clk;

  axis_word_serializer #(.WORD_WIDTH(WW), .BIG_ENDIAN(0)) dut_le (
    .clk(clk), .arstn(arstn), .s_word(s_word), .s_len(s_len), .s_last(s_last),
    .s_valid(s_valid), .s_ready(le_ready), .m_axis_tdata(le_data),
    .m_axis_tvalid(le_valid), .m_axis_tready(m_axis_tready), .m_axis_tlast(le_last)
  );

  axis_word_serializer #(.WORD_WIDTH(WW), .BIG_ENDIAN(1)) dut_be (
    .clk(clk), .arstn(arstn), .s_word(s_word), .s_len(s_len), .s_last(s_last),
    .s_valid(s_valid), .s_ready(be_ready), .m_axis_tdata(be_data),
    .m_axis_tvalid(be_valid), .m_axis_tready(m_axis_tready), .m_axis_tlast(be_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the bytes a word should produce, in each byte order, with the frame flag on the final one.
  task automatic push_word(input logic [WW-1:0] w, input logic [LW-1:0] len, input logic last);
    int unsigned n;
    n = ((len == 0) || (int'(len) > NB)) ? NB : int'(len);
    for (int i = 0; i < int'(n); i++)
      q_le.push_back({last && (i == int'(n) - 1), w[8*i +: 8]});
    for (int i = int'(n) - 1; i >= 0; i--)
      q_be.push_back({last && (i == 0), w[8*i +: 8]});
  endtask

  // One clock: entered and left at the falling edge, with inputs already set.
  task automatic cycle();
    logic rdy, exp_valid, exp_ready, xfer;
    logic [8:0] f_le, f_be;
    rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axis_tready = rdy;
    #1;
    exp_valid = (q_le.size() != 0);
    exp_ready = running && (!exp_valid || (rdy && (q_le.size() == 1)));
    chk("tvalid_le", 32'(le_valid), 32'(exp_valid));
    chk("tvalid_be", 32'(be_valid), 32'(exp_valid));
    chk("s_ready_le", 32'(le_ready), 32'(exp_ready));
    chk("s_ready_be", 32'(be_ready), 32'(exp_ready));
    if (!arstn) begin
      chk("rst_tdata_le", 32'(le_data), 32'h0);
      chk("rst_tdata_be", 32'(be_data), 32'h0);
    end
    if (prev_stall) begin
      chk("hold_le", 32'({le_last, le_data}), 32'(prev_le));
      chk("hold_be", 32'({be_last, be_data}), 32'(prev_be));
    end
    xfer = exp_valid && rdy;
    if (xfer) begin
      f_le = q_le.pop_front();
      f_be = q_be.pop_front();
      chk("beat_le", 32'({le_last, le_data}), 32'(f_le));
      chk("beat_be", 32'({be_last, be_data}), 32'(f_be));
    end
    prev_stall = exp_valid && !rdy;
    prev_le    = {le_last, le_data};
    prev_be    = {be_last, be_data};
    accepted   = s_valid && exp_ready;
    if (accepted) push_word(s_word, s_len, s_last);
    @(posedge clk);
    if (arstn) running = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [WW-1:0] w, input logic [LW-1:0] len, input logic last);
    s_word  = w;
    s_len   = len;
    s_last  = last;
    s_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 64 && !accepted; i++) cycle();
    chk("accept_timeout", 32'(accepted), 32'h1);
  endtask

  task automatic drain();
    s_valid = 1'b0;
    for (int i = 0; i < 256 && q_le.size() != 0; i++) cycle();
    chk("drain_timeout", 32'(q_le.size()), 32'h0);
    cycle();
  endtask

  // Directed and randomized sequence.
  initial begin
    s_valid = 1'b0; s_word = '0; s_len = '0; s_last = 1'b0; m_axis_tready = 1'b0;
    rand_rdy = 1'b0; running = 1'b0; accepted = 1'b0; prev_stall = 1'b0;
    prev_le = '0; prev_be = '0;

    // Reset held three cycles, then released between edges.
    @(negedge clk);
    repeat (3) cycle();
    arstn = 1'b1;
    cycle();
    cycle();

    // Full word, frame end.
    send_word(32'h44332211, 3'd0, 1'b1);
    drain();

    // Back-to-back words with no bubbles.
    send_word(32'hA3A2A1A0, 3'd0, 1'b0);
    send_word(32'hB3B2B1B0, 3'd0, 1'b1);
    drain();

    // Partial and oversize lengths.
    send_word(32'hAABBCCDD, 3'd2, 1'b1);
    drain();
    send_word(32'hAABBCCDD, 3'd7, 1'b1);
    drain();
    send_word(32'h12345678, 3'd1, 1'b0);
    send_word(32'h9ABCDEF0, 3'd3, 1'b1);
    drain();

    // Random backpressure over directed and random words.
    rand_rdy = 1'b1;
    send_word(32'hA3A2A1A0, 3'd0, 1'b0);
    send_word(32'hB3B2B1B0, 3'd0, 1'b1);
    for (int k = 0; k < 40; k++)
      send_word($urandom, LW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    drain();
    rand_rdy = 1'b0;

    // Reset after two of four bytes have gone out.
    send_word(32'h44332211, 3'd0, 1'b1);
    s_valid = 1'b0;
    cycle();
    cycle();
    #2;
    arstn = 1'b0;
    #1;
    chk("async_rst_tvalid_le", 32'(le_valid), 32'h0);
    chk("async_rst_tvalid_be", 32'(be_valid), 32'h0);
    chk("async_rst_tdata_le", 32'(le_data), 32'h0);
    chk("async_rst_tdata_be", 32'(be_data), 32'h0);
    q_le.delete();
    q_be.delete();
    running = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    arstn = 1'b1;
    cycle();
    cycle();
    send_word(32'h00000055, 3'd1, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_word_serializer.md
Name: axis_word_serializer

Overview:
- Transmit-side AXI4-Stream source: accepts one wide parallel word per valid/ready handshake and emits it as a stream of 8-bit beats.
- Asserts tlast on the final byte of a word only when that word is flagged as last-of-frame.
- Sits between core logic producing wide results (spike/output words) and byte-oriented stream consumers (stream registers, UART/host links).
- Fully registered master outputs; back-to-back words stream with no bubble cycles.

Parameters:
- WORD_WIDTH, 32, input word width in bits; must be a multiple of 8 and >= 8.
- BIG_ENDIAN, 0, byte order: 0 = byte 0 (bits 7:0) sent first; 1 = most-significant byte sent first.
- LEN_WIDTH, $clog2(WORD_WIDTH/8+1), width of the byte-count input; derived, not overridden.

Ports:
- clk  in  1  clock
- arstn  in  1  reset, asynchronous, active-low
- s_word  in  WORD_WIDTH  parallel word to transmit
- s_len  in  LEN_WIDTH  bytes of s_word to send; 0 or > WORD_WIDTH/8 means WORD_WIDTH/8
- s_last  in  1  word ends a frame (tlast on its final byte)
- s_valid  in  1  word-side valid
- s_ready  out  1  word-side ready
- m_axis_tdata  out  8  stream byte
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  end of frame

Behaviour:
- Reset (arstn low, async):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - Internal remaining-count=0.
  - run_q=0, so s_ready=0.
  - run_q sets on the first clk edge after arstn deasserts.
- Two states:
  - IDLE: remaining==0, m_axis_tvalid=0.
  - SEND: remaining>=1, m_axis_tvalid=1.
- s_ready = run_q && (!m_axis_tvalid || (m_axis_tready && remaining==1)).
  - This is a combinational path from m_axis_tready to s_ready; it is permitted and documented.
  - s_valid is never used to form s_ready.
- Word accept (s_valid && s_ready at edge N):
  - Load shift register with s_word; set remaining = effective len L; latch s_last.
  - From cycle N+1: m_axis_tvalid=1 and m_axis_tdata = first byte per BIG_ENDIAN.
  - Latency is 1 cycle.
- Beat transfer (m_axis_tvalid && m_axis_tready), with remaining>1:
  - Shift by 8 bits toward the output byte.
  - Decrement remaining.
  - Next byte is presented the following cycle.
- Final beat (remaining==1 transfer):
  - If a new word is accepted on the same edge, load it: no bubble.
  - Otherwise go to IDLE: m_axis_tvalid=0, tdata holds its last value.
- m_axis_tlast = latched s_last && remaining==1, registered alongside tdata.
- Held outputs: while m_axis_tvalid=1 and m_axis_tready=0, tdata, tlast and tvalid stay stable (AXIS rule).
- Partial words with BIG_ENDIAN=0 and L<max: bytes 0..L-1 are sent, upper bytes dropped.
- Partial words with BIG_ENDIAN=1 and L<max: the L least-significant bytes are sent, most significant of those first. Example: WORD_WIDTH=32, L=2, s_word=0xAABBCCDD sends 0xCC, 0xDD.
- Reset mid-word: the word is discarded immediately and no partial tlast is emitted. After reset, the next accepted word starts fresh.
- Throughput: 1 byte/cycle sustained when m_axis_tready=1.

Decomposition:
- Shared package (axis_pkg):
  - BYTE_WIDTH=8 constant.
  - Byte-order constants (ORDER_LITTLE=0, ORDER_BIG=1).
  - Helper function for effective length clamp (len==0 || len>max -> max).
- No sub-module: one always_comb for next-state/ready, one async-reset always_ff for state/datapath; ~150-220 lines.

Test Plan:
- Reset: hold arstn=0 for 3 cycles, release -> s_ready=0 in the release cycle, 1 on the next edge; m_axis_tvalid=0 and tdata=0 throughout reset.
- Full-word little-endian frame end (BIG_ENDIAN=0, WORD_WIDTH=32), s_word=0x44332211, s_len=0, s_last=1, m_axis_tready=1 -> bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after accept; tlast=1 only on 0x44.
- Back-to-back words, no bubbles: words 0xA3A2A1A0 (last=0) and 0xB3B2B1B0 (last=1) offered continuously, m_axis_tready=1 -> 8 consecutive valid beats A0..A3,B0..B3; s_ready high on the edge A3 transfers; tlast only on B3.
- Backpressure: random m_axis_tready with ~50% duty -> tdata/tlast stable while stalled; byte sequence identical to the no-stall run; s_ready=0 while remaining>1.
- Partial length, big-endian (BIG_ENDIAN=1), s_word=0xAABBCCDD, s_len=2, s_last=1 -> 0xCC then 0xDD with tlast=1; s_len=7 -> treated as 4: 0xAA,0xBB,0xCC,0xDD.
- Reset mid-word: assert arstn low after 2 of 4 bytes transferred -> m_axis_tvalid drops asynchronously; after release, word 0x00000055 with s_len=1, s_last=1 -> single beat 0x55 with tlast=1, no stale bytes.
